// File: rtl/word_packer.sv
// word_packer: gathers WIDTH-bit beats into LANES-beat words, queues them in a
// DEPTH-entry FIFO and presents them on a valid/ready interface. Partial words
// can be flushed with a lane-keep mask; dropped words set a sticky overflow flag.
module word_packer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           din,
  input  logic                       valid_in,
  input  logic                       flush,
  output logic [LANES*WIDTH-1:0]     dout,
  output logic [LANES-1:0]           keep,
  output logic                       valid_out,
  input  logic                       ready_in,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow
);

  localparam int unsigned CW = $clog2(LANES);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned DW = LANES * WIDTH;

  // Assembly register
  logic [DW-1:0]    data_q, data_d;
  logic [LANES-1:0] mask_q, mask_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // FIFO state
  logic [DW-1:0]    mem_data_q [DEPTH];
  logic [DW-1:0]    mem_data_d [DEPTH];
  logic [LANES-1:0] mem_keep_q [DEPTH];
  logic [LANES-1:0] mem_keep_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             overflow_q, overflow_d;

  // Combinational intermediates
  logic [DW-1:0]    beat_word;
  logic [LANES-1:0] beat_mask;
  logic [CW:0]      cnt_after;
  logic             word_full;
  logic             push;
  logic             push_ok;
  logic             pop;
  logic [DW-1:0]    push_word;
  logic [LANES-1:0] push_keep;

  assign valid_out = (level_q != '0);
  assign pop       = valid_out && ready_in;

  // Merge the current beat into the assembly word and decide whether to push
  always_comb begin
    beat_word = data_q;
    beat_mask = mask_q;
    for (int i = 0; i < LANES; i++) begin
      if (valid_in && (cnt_q == CW'(i))) begin
        beat_word[i*WIDTH +: WIDTH] = din;
        beat_mask[i]                = 1'b1;
      end
    end
    cnt_after = {1'b0, cnt_q} + (CW + 1)'(valid_in);
    word_full = valid_in && (cnt_q == CW'(LANES - 1));
    // A flush on a completing beat rides on the full-word push, never a second one
    push      = word_full || (flush && (cnt_after != '0));
    push_word = beat_word;
    push_keep = word_full ? '1 : beat_mask;
    push_ok   = push && ((level_q < LW'(DEPTH)) || pop);
  end

  // Assembly next state: clear on any push, even a dropped one
  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    cnt_d  = cnt_q;
    if (push) begin
      data_d = '0;
      mask_d = '0;
      cnt_d  = '0;
    end else if (valid_in) begin
      data_d = beat_word;
      mask_d = beat_mask;
      cnt_d  = cnt_q + CW'(1);
    end
  end

  // FIFO next state: storage write, pointer advance, level and sticky overflow
  always_comb begin
    mem_data_d = mem_data_q;
    mem_keep_d = mem_keep_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q | (push && !push_ok);
    if (push_ok) begin
      mem_data_d[wr_ptr_q] = push_word;
      mem_keep_d[wr_ptr_q] = push_keep;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    unique case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Control and assembly registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q     <= '0;
      mask_q     <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      data_q     <= data_d;
      mask_q     <= mask_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; contents are don't-care while empty since outputs are gated
  always_ff @(posedge clk) begin
    mem_data_q <= mem_data_d;
    mem_keep_q <= mem_keep_d;
  end

  // Output gating: nothing leaks out while the queue is empty
  always_comb begin
    dout = '0;
    keep = '0;
    if (valid_out) begin
      dout = mem_data_q[rd_ptr_q];
      keep = mem_keep_q[rd_ptr_q];
    end
  end

  assign level    = level_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_word_packer.sv
// Directed self-checking bench for word_packer (WIDTH=8, LANES=4, DEPTH=4).
module tb_word_packer;

  logic        clk;
  logic        rst;
  logic [7:0]  din;
  logic        valid_in;
  logic        flush;
  logic [31:0] dout;
  logic [3:0]  keep;
  logic        valid_out;
  logic        ready_in;
  logic [2:0]  level;
  logic        overflow;

  int n_cmp;
  int n_err;

  word_packer #(
    .WIDTH(8),
    .LANES(4),
    .DEPTH(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .valid_in (valid_in),
    .flush    (flush),
    .dout     (dout),
    .keep     (keep),
    .valid_out(valid_out),
    .ready_in (ready_in),
    .level    (level),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [7:0] b);
    valid_in = 1'b1;
    din      = b;
    tick();
    valid_in = 1'b0;
    din      = '0;
  endtask

  // Four consecutive beats, lane 0 first
  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) beat(w[i*8 +: 8]);
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    din      = '0;
    valid_in = 1'b0;
    flush    = 1'b0;
    ready_in = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset values
    chk("rst_dout", dout, 32'h0);
    chk("rst_keep", {28'h0, keep}, 32'h0);
    chk("rst_valid", {31'h0, valid_out}, 32'h0);
    chk("rst_level", {29'h0, level}, 32'h0);
    chk("rst_ovf", {31'h0, overflow}, 32'h0);

    // Full word with ready held high
    ready_in = 1'b1;
    send_word(32'h44332211);
    chk("full_valid", {31'h0, valid_out}, 32'h1);
    chk("full_dout", dout, 32'h44332211);
    chk("full_keep", {28'h0, keep}, 32'hF);
    chk("full_level", {29'h0, level}, 32'h1);
    tick();
    chk("full_popped_valid", {31'h0, valid_out}, 32'h0);
    chk("full_popped_level", {29'h0, level}, 32'h0);
    chk("full_popped_dout", dout, 32'h0);

    // Partial flush, then a full word behind it
    ready_in = 1'b0;
    beat(8'hAA);
    beat(8'hBB);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("part_dout", dout, 32'h0000BBAA);
    chk("part_keep", {28'h0, keep}, 32'h3);
    chk("part_level", {29'h0, level}, 32'h1);
    send_word(32'h04030201);
    chk("part_level2", {29'h0, level}, 32'h2);
    chk("part_head_held", dout, 32'h0000BBAA);
    ready_in = 1'b1;
    tick();
    chk("part_next_dout", dout, 32'h04030201);
    chk("part_next_keep", {28'h0, keep}, 32'hF);
    chk("part_next_level", {29'h0, level}, 32'h1);
    tick();
    chk("part_drained", {31'h0, valid_out}, 32'h0);

    // Flush coinciding with the completing beat
    ready_in = 1'b0;
    beat(8'h11);
    beat(8'h22);
    beat(8'h33);
    flush = 1'b1;
    beat(8'h44);
    flush = 1'b0;
    chk("fcb_level", {29'h0, level}, 32'h1);
    chk("fcb_dout", dout, 32'h44332211);
    chk("fcb_keep", {28'h0, keep}, 32'hF);
    tick();
    chk("fcb_level_idle", {29'h0, level}, 32'h1);
    ready_in = 1'b1;
    tick();
    chk("fcb_drained", {29'h0, level}, 32'h0);

    // Backpressure and overflow
    ready_in = 1'b0;
    send_word(32'hA3A2A1A0);
    send_word(32'hB3B2B1B0);
    send_word(32'hC3C2C1C0);
    send_word(32'hD3D2D1D0);
    chk("bp_level4", {29'h0, level}, 32'h4);
    chk("bp_ovf0", {31'h0, overflow}, 32'h0);
    send_word(32'hE3E2E1E0);
    chk("bp_level_still4", {29'h0, level}, 32'h4);
    chk("bp_ovf1", {31'h0, overflow}, 32'h1);
    ready_in = 1'b1;
    chk("bp_w1", dout, 32'hA3A2A1A0);
    tick();
    chk("bp_w2", dout, 32'hB3B2B1B0);
    tick();
    chk("bp_w3", dout, 32'hC3C2C1C0);
    tick();
    chk("bp_w4", dout, 32'hD3D2D1D0);
    tick();
    chk("bp_empty", {31'h0, valid_out}, 32'h0);
    chk("bp_ovf_sticky", {31'h0, overflow}, 32'h1);

    // Full FIFO with simultaneous push and pop
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("sp_ovf_cleared", {31'h0, overflow}, 32'h0);
    ready_in = 1'b0;
    send_word(32'h13121110);
    send_word(32'h23222120);
    send_word(32'h33323130);
    send_word(32'h43424140);
    beat(8'h50);
    beat(8'h51);
    beat(8'h52);
    ready_in = 1'b1;
    beat(8'h53);
    ready_in = 1'b0;
    chk("sp_level", {29'h0, level}, 32'h4);
    chk("sp_ovf", {31'h0, overflow}, 32'h0);
    chk("sp_head2", dout, 32'h23222120);
    ready_in = 1'b1;
    tick();
    chk("sp_head3", dout, 32'h33323130);
    tick();
    chk("sp_head4", dout, 32'h43424140);
    tick();
    chk("sp_head5", dout, 32'h53525150);
    tick();
    chk("sp_empty", {31'h0, valid_out}, 32'h0);

    // Reset mid-operation with a queued word and a partial word
    ready_in = 1'b0;
    send_word(32'h99887766);
    beat(8'h55);
    beat(8'h66);
    chk("mr_queued", {29'h0, level}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_dout", dout, 32'h0);
    chk("mr_keep", {28'h0, keep}, 32'h0);
    chk("mr_valid", {31'h0, valid_out}, 32'h0);
    chk("mr_level", {29'h0, level}, 32'h0);
    send_word(32'h04030201);
    chk("mr_new_level", {29'h0, level}, 32'h1);
    chk("mr_new_dout", dout, 32'h04030201);
    chk("mr_new_keep", {28'h0, keep}, 32'hF);
    ready_in = 1'b1;
    tick();
    chk("mr_only_one", {31'h0, valid_out}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
